// File: rtl/vga_sync_gen.sv
// 640x480 @ 60 Hz VGA timing generator: pixel-rate divider, horizontal/vertical
// counters and registered sync / visible-area / coordinate decodes.
module vga_sync_gen #(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       clk,
  input  logic       clr,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_on,
  output logic [9:0] Pixel_X,
  output logic [8:0] Pixel_Y,
  output logic       pix_tick,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEGIN = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEGIN = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] div_cnt;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       frame_wrap;

  logic tick;
  logic h_end;
  logic v_end;
  logic h_vis;
  logic v_vis;
  logic in_hsync;
  logic in_vsync;

  assign tick     = (div_cnt == DIV_LAST);
  assign h_end    = (h_cnt == H_LAST);
  assign v_end    = (v_cnt == V_LAST);
  assign h_vis    = (h_cnt < H_VIS);
  assign v_vis    = (v_cnt < V_VIS);
  assign in_hsync = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
  assign in_vsync = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);

  // Divider and raster counters. frame_wrap marks the tick that returns the
  // raster to (0,0) by counting, so a reset never looks like a new frame.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register reading the
    // pre-edge values of the others, which is what makes them a coherent set.
    if (!clr) begin
      div_cnt    <= '0;
      h_cnt      <= '0;
      v_cnt      <= '0;
      frame_wrap <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 10'd1;
      frame_wrap <= tick && h_end && v_end;
      if (tick) begin
        if (h_end) begin
          h_cnt <= '0;
          v_cnt <= v_end ? '0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  // All outputs decode the same counter snapshot, so they lag the counters by
  // one clk together and never skew against each other.
  always_ff @(posedge clk) begin
    if (!clr) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      vga_on      <= 1'b0;
      Pixel_X     <= '0;
      Pixel_Y     <= '0;
      pix_tick    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= !in_hsync;
      vsync       <= !in_vsync;
      vga_on      <= h_vis && v_vis;
      Pixel_X     <= h_cnt;
      // Blank lines would otherwise alias onto low rows through the 9-bit slice.
      Pixel_Y     <= v_vis ? v_cnt[8:0] : '0;
      pix_tick    <= tick;
      frame_start <= frame_wrap;
    end
  end

endmodule
